uart_rx_word: RTL



---
 rtl/uart_rx_word.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_word.sv
// 8N1 UART receiver that reassembles little-endian words from consecutive bytes
// and presents them on a valid/ready interface, with frame-error and idle-timeout recovery.
module uart_rx_word #(
    parameter int CLKS_PER_BIT = 64,
    parameter int TIMEOUT_BITS = 20,
    parameter int NB_WORD      = 32
) (
    input  logic               i_Clock,
    input  logic               i_Rst_n,
    input  logic               i_Rx_Serial,
    input  logic               i_Word_Ready,
    output logic [NB_WORD-1:0] o_Word,
    output logic               o_Word_Valid,
    output logic [7:0]         o_Byte,
    output logic               o_Byte_Valid,
    output logic               o_Rx_Active,
    output logic               o_Frame_Err,
    output logic               o_Overrun,
    output logic               o_Timeout
);

    localparam int NB_BYTES    = NB_WORD / 8;
    localparam int IDX_W       = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;
    localparam int CNT_W       = $clog2(CLKS_PER_BIT) + 1;
    localparam int TIMEOUT_CYC = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int IDLE_W      = $clog2(TIMEOUT_CYC + 1);

    localparam logic [CNT_W-1:0]  HALF_CNT   = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT_CYC);
    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(NB_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_CLEANUP
    } state_t;

    logic [1:0]         rx_sync_q;
    logic               rx_s;

    state_t             state_q,      state_d;
    logic [CNT_W-1:0]   clk_cnt_q,    clk_cnt_d;
    logic [2:0]         bit_idx_q,    bit_idx_d;
    logic [7:0]         shift_q,      shift_d;
    logic [IDX_W-1:0]   byte_idx_q,   byte_idx_d;
    logic [IDLE_W-1:0]  idle_cnt_q,   idle_cnt_d;
    logic [NB_WORD-1:0] shadow_q,     shadow_d;
    logic [NB_WORD-1:0] word_q,       word_d;
    logic               word_valid_q, word_valid_d;
    logic [7:0]         byte_q,       byte_d;
    logic               byte_valid_q, byte_valid_d;
    logic               rx_active_q,  rx_active_d;
    logic               frame_err_q,  frame_err_d;
    logic               overrun_q,    overrun_d;
    logic               timeout_q,    timeout_d;

    // Idle-high line: synchroniser resets to 1 so release never looks like a start bit.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            rx_sync_q <= 2'b11;
        end else begin
            rx_sync_q <= {rx_sync_q[0], i_Rx_Serial};
        end
    end

    assign rx_s = rx_sync_q[1];

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        state_d      = state_q;
        clk_cnt_d    = clk_cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        byte_idx_d   = byte_idx_q;
        idle_cnt_d   = idle_cnt_q;
        shadow_d     = shadow_q;
        word_d       = word_q;
        word_valid_d = word_valid_q & ~i_Word_Ready;
        byte_d       = byte_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        overrun_d    = 1'b0;
        timeout_d    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    state_d    = S_START;
                    clk_cnt_d  = '0;
                    idle_cnt_d = '0;
                end else if (byte_idx_q != '0) begin
                    if (idle_cnt_q == IDLE_LIMIT) begin
                        byte_idx_d = '0;
                        idle_cnt_d = '0;
                        timeout_d  = 1'b1;
                    end else begin
                        idle_cnt_d = idle_cnt_q + IDLE_W'(1);
                    end
                end else begin
                    idle_cnt_d = '0;
                end
            end

            S_START: begin
                if (clk_cnt_q == HALF_CNT) begin
                    clk_cnt_d = '0;
                    if (!rx_s) begin
                        state_d   = S_DATA;
                        bit_idx_d = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end

            S_DATA: begin
                if (clk_cnt_q == FULL_CNT) begin
                    clk_cnt_d = '0;
                    shift_d   = {rx_s, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end

            S_STOP: begin
                if (clk_cnt_q == FULL_CNT) begin
                    clk_cnt_d = '0;
                    state_d   = S_CLEANUP;
                    if (rx_s) begin
                        byte_d       = shift_q;
                        byte_valid_d = 1'b1;
                        shadow_d[{byte_idx_q, 3'b000} +: 8] = shift_q;
                        if (byte_idx_q == LAST_IDX) begin
                            byte_idx_d = '0;
                            // A word can replace the held one only if it is being taken this cycle.
                            if (!word_valid_q || i_Word_Ready) begin
                                word_d       = shadow_d;
                                word_valid_d = 1'b1;
                            end else begin
                                overrun_d = 1'b1;
                            end
                        end else begin
                            byte_idx_d = byte_idx_q + IDX_W'(1);
                        end
                    end else begin
                        frame_err_d = 1'b1;
                        byte_idx_d  = '0;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end

            S_CLEANUP: begin
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase

        rx_active_d = (state_d == S_START) || (state_d == S_DATA) || (state_d == S_STOP);
    end

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q      <= S_IDLE;
            clk_cnt_q    <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            byte_idx_q   <= '0;
            idle_cnt_q   <= '0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
            byte_q       <= '0;
            byte_valid_q <= 1'b0;
            rx_active_q  <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            clk_cnt_q    <= clk_cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            byte_idx_q   <= byte_idx_d;
            idle_cnt_q   <= idle_cnt_d;
            word_q       <= word_d;
            word_valid_q <= word_valid_d;
            byte_q       <= byte_d;
            byte_valid_q <= byte_valid_d;
            rx_active_q  <= rx_active_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
            timeout_q    <= timeout_d;
        end
    end

    // NOTE: the shadow is pure data, fully rewritten before it is ever copied to o_Word, so it needs no reset.
    always_ff @(posedge i_Clock) begin
        shadow_q <= shadow_d;
    end

    assign o_Word       = word_q;
    assign o_Word_Valid = word_valid_q;
    assign o_Byte       = byte_q;
    assign o_Byte_Valid = byte_valid_q;
    assign o_Rx_Active  = rx_active_q;
    assign o_Frame_Err  = frame_err_q;
    assign o_Overrun    = overrun_q;
    assign o_Timeout    = timeout_q;

endmodule
